fp_gp_xfer_ctrl: RTL and testbench

- Sequences MTC1/MFC1 register transfers between the GP and FP register files.
- Accepts one decoded transfer request at a time and reads the source file.
- Steers the read data through an internal fp_gp_transfer datapath, registers the result, then arbitrates the destination write port against the main pipeline.
- Pipeline writes have priority, with a bounded-wait starvation guard.

---
 rtl/fp_gp_pkg.sv | 17 +
 rtl/fp_gp_transfer.sv | 15 +
 rtl/fp_gp_xfer_ctrl.sv | 146 ++++++++++++++
 tb/tb_fp_gp_xfer_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fp_gp_pkg.sv
// Shared types and constants for the GP<->FP register transfer controller.
package fp_gp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      CAPT  = 2'd2,
      WRITE = 2'd3
   } xfer_state_t;

   localparam logic XFER_MTC1 = 1'b1;
   localparam logic XFER_MFC1 = 1'b0;

   // GP register 0 is hardwired to zero and never written.
   localparam int GP_ZERO_REG = 0;

endpackage

// File: rtl/fp_gp_transfer.sv
// CAPT-stage result mux: picks the source file's read data for the transfer direction.
module fp_gp_transfer
   import fp_gp_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              i_is_mtc1,
   input  logic [DATA_W-1:0] i_gp_data,
   input  logic [DATA_W-1:0] i_fp_data,
   output logic [DATA_W-1:0] o_data
);

   assign o_data = (i_is_mtc1 == XFER_MTC1) ? i_gp_data : i_fp_data;

endmodule

// File: rtl/fp_gp_xfer_ctrl.sv
// MTC1/MFC1 transfer sequencer: read source file, capture, then arbitrate the
// destination write port against the pipeline with a bounded-wait stall.
//
// state | meaning
// IDLE  | ready for a request; latches direction, src and dst on req_valid
// READ  | one-cycle read of the source file at src
// CAPT  | source read data registered into r_data
// WRITE | write dst; yield to pipeline up to MAX_WAIT cycles, then stall it
module fp_gp_xfer_ctrl
   import fp_gp_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_is_mtc1,
   input  logic [ADDR_W-1:0] req_src,
   input  logic [ADDR_W-1:0] req_dst,
   output logic              gp_rd_en,
   output logic [ADDR_W-1:0] gp_rd_addr,
   output logic              fp_rd_en,
   output logic [ADDR_W-1:0] fp_rd_addr,
   input  logic [DATA_W-1:0] gp_rd_data,
   input  logic [DATA_W-1:0] fp_rd_data,
   output logic              gp_wr_en,
   output logic [ADDR_W-1:0] gp_wr_addr,
   output logic [DATA_W-1:0] gp_wr_data,
   output logic              fp_wr_en,
   output logic [ADDR_W-1:0] fp_wr_addr,
   output logic [DATA_W-1:0] fp_wr_data,
   input  logic              pipe_gp_wr_req,
   input  logic              pipe_fp_wr_req,
   output logic              pipe_stall,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   xfer_state_t       r_state;
   xfer_state_t       w_next;
   logic              r_is_mtc1;
   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [DATA_W-1:0] r_data;
   logic [CNT_W-1:0]  r_wait_cnt;

   logic [DATA_W-1:0] w_xfer_data;
   logic              w_conflict;
   logic              w_gp_zero;
   logic              w_yield;
   logic              w_wr;

   fp_gp_transfer #(.DATA_W(DATA_W)) u_xfer (
      .i_is_mtc1 (r_is_mtc1),
      .i_gp_data (gp_rd_data),
      .i_fp_data (fp_rd_data),
      .o_data    (w_xfer_data)
   );

   // Only the destination file's pipeline request can block the write.
   assign w_conflict = (r_is_mtc1 == XFER_MTC1) ? pipe_fp_wr_req : pipe_gp_wr_req;
   assign w_gp_zero  = (r_is_mtc1 == XFER_MFC1) && (r_dst == ADDR_W'(GP_ZERO_REG));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_is_mtc1  <= 1'b0;
         r_src      <= '0;
         r_dst      <= '0;
         r_data     <= '0;
         r_wait_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && req_valid) begin
            r_is_mtc1 <= req_is_mtc1;
            r_src     <= req_src;
            r_dst     <= req_dst;
         end
         if (r_state == CAPT) begin
            r_data <= w_xfer_data;
         end
         if (r_state == WRITE && w_next != WRITE) begin
            r_wait_cnt <= '0;
         end else if (w_yield) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_next     = r_state;
      req_ready  = 1'b0;
      gp_rd_en   = 1'b0;
      fp_rd_en   = 1'b0;
      w_wr       = 1'b0;
      w_yield    = 1'b0;
      pipe_stall = 1'b0;
      done       = 1'b0;
      case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) w_next = READ;
         end
         READ: begin
            gp_rd_en = (r_is_mtc1 == XFER_MTC1);
            fp_rd_en = (r_is_mtc1 == XFER_MFC1);
            w_next   = CAPT;
         end
         CAPT: w_next = WRITE;
         WRITE: begin
            if (w_gp_zero) begin
               done   = 1'b1;
               w_next = IDLE;
            end else if (!w_conflict) begin
               w_wr   = 1'b1;
               done   = 1'b1;
               w_next = IDLE;
            end else if (r_wait_cnt < CNT_W'(MAX_WAIT)) begin
               w_yield = 1'b1;
            end else begin
               pipe_stall = 1'b1;
               w_wr       = 1'b1;
               done       = 1'b1;
               w_next     = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   assign busy       = (r_state != IDLE);
   assign gp_rd_addr = gp_rd_en ? r_src : '0;
   assign fp_rd_addr = fp_rd_en ? r_src : '0;
   assign fp_wr_en   = w_wr && (r_is_mtc1 == XFER_MTC1);
   assign gp_wr_en   = w_wr && (r_is_mtc1 == XFER_MFC1);
   assign fp_wr_addr = fp_wr_en ? r_dst  : '0;
   assign fp_wr_data = fp_wr_en ? r_data : '0;
   assign gp_wr_addr = gp_wr_en ? r_dst  : '0;
   assign gp_wr_data = gp_wr_en ? r_data : '0;

endmodule

// File: tb/tb_fp_gp_xfer_ctrl.sv
// Scoreboard bench for fp_gp_xfer_ctrl: expected writes are queued at request
// time and retired against the DUT's write/done outputs.
module tb_fp_gp_xfer_ctrl;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int MW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready, req_is_mtc1;
   logic [AW-1:0] req_src, req_dst;
   logic          gp_rd_en, fp_rd_en;
   logic [AW-1:0] gp_rd_addr, fp_rd_addr;
   logic [DW-1:0] gp_rd_data, fp_rd_data;
   logic          gp_wr_en, fp_wr_en;
   logic [AW-1:0] gp_wr_addr, fp_wr_addr;
   logic [DW-1:0] gp_wr_data, fp_wr_data;
   logic          pipe_gp_wr_req, pipe_fp_wr_req;
   logic          pipe_stall, busy, done;

   logic [DW-1:0] gp_mem [32];
   logic [DW-1:0] fp_mem [32];

   typedef struct {
      logic          is_mtc1;
      logic [AW-1:0] dst;
      logic [DW-1:0] data;
      logic          wr;
      int            wcyc;
      logic          stall;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   fp_gp_xfer_ctrl #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_mtc1(req_is_mtc1),
      .req_src(req_src), .req_dst(req_dst),
      .gp_rd_en(gp_rd_en), .gp_rd_addr(gp_rd_addr),
      .fp_rd_en(fp_rd_en), .fp_rd_addr(fp_rd_addr),
      .gp_rd_data(gp_rd_data), .fp_rd_data(fp_rd_data),
      .gp_wr_en(gp_wr_en), .gp_wr_addr(gp_wr_addr), .gp_wr_data(gp_wr_data),
      .fp_wr_en(fp_wr_en), .fp_wr_addr(fp_wr_addr), .fp_wr_data(fp_wr_data),
      .pipe_gp_wr_req(pipe_gp_wr_req), .pipe_fp_wr_req(pipe_fp_wr_req),
      .pipe_stall(pipe_stall), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Register-file models: read data valid one cycle after rd_en.
   always @(posedge clk) begin
      if (gp_rd_en) gp_rd_data <= gp_mem[gp_rd_addr];
      if (fp_rd_en) fp_rd_data <= fp_mem[fp_rd_addr];
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic run_xfer(input logic mtc1, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                           input int fp_n, input int gp_n);
      exp_t e;
      int   n;
      bit   done_seen;
      logic wr_now;
      e.is_mtc1 = mtc1;
      e.dst     = dst;
      e.data    = mtc1 ? gp_mem[src] : fp_mem[src];
      e.wr      = !(!mtc1 && dst == 0);
      n         = mtc1 ? fp_n : gp_n;
      e.wcyc    = e.wr ? 3 + ((n > MW) ? MW : n) : 3;
      e.stall   = e.wr && (n > MW);
      sb.push_back(e);

      chk("req_ready_idle", req_ready, 1);
      req_valid = 1'b1; req_is_mtc1 = mtc1; req_src = src; req_dst = dst;
      pipe_fp_wr_req = 1'b0; pipe_gp_wr_req = 1'b0;
      done_seen = 0;
      for (int cyc = 1; cyc <= 20 && !done_seen; cyc++) begin
         @(posedge clk); #1;
         // Garbage on req_* while busy must be ignored.
         req_valid = (cyc <= 2); req_is_mtc1 = ~mtc1; req_src = ~src; req_dst = ~dst;
         pipe_fp_wr_req = (cyc >= 3 && cyc < 3 + fp_n);
         pipe_gp_wr_req = (cyc >= 3 && cyc < 3 + gp_n);
         @(negedge clk);
         e = sb[0];
         wr_now = (cyc == e.wcyc) && e.wr;
         chk("busy", busy, 1);
         chk("req_ready_busy", req_ready, 0);
         chk("gp_rd_en", gp_rd_en, (cyc == 1) && mtc1);
         chk("fp_rd_en", fp_rd_en, (cyc == 1) && !mtc1);
         if (cyc == 1) chk("rd_addr", mtc1 ? gp_rd_addr : fp_rd_addr, src);
         chk("fp_wr_en", fp_wr_en, wr_now && e.is_mtc1);
         chk("gp_wr_en", gp_wr_en, wr_now && !e.is_mtc1);
         if (wr_now) begin
            chk("wr_addr", e.is_mtc1 ? fp_wr_addr : gp_wr_addr, e.dst);
            chk("wr_data", e.is_mtc1 ? fp_wr_data : gp_wr_data, e.data);
         end
         chk("pipe_stall", pipe_stall, wr_now && e.stall);
         chk("done", done, cyc == e.wcyc);
         if (done || cyc == e.wcyc) begin
            done_seen = 1;
            void'(sb.pop_front());
         end
      end
      if (!done_seen) begin
         chk("done_timeout", 0, 1);
         if (sb.size() > 0) void'(sb.pop_front());
      end
      @(posedge clk); #1;
      req_valid = 1'b0; pipe_fp_wr_req = 1'b0; pipe_gp_wr_req = 1'b0;
      @(negedge clk);
      chk("busy_after", busy, 0);
      chk("req_ready_after", req_ready, 1);
   endtask

   initial begin
      int wr_cnt;
      rst = 1'b1;
      req_valid = 1'b0; req_is_mtc1 = 1'b0; req_src = '0; req_dst = '0;
      pipe_gp_wr_req = 1'b0; pipe_fp_wr_req = 1'b0;
      gp_rd_data = '0; fp_rd_data = '0;
      for (int i = 0; i < 32; i++) begin
         gp_mem[i] = 32'h1000_0000 + i * 32'h0101_0101;
         fp_mem[i] = 32'hA000_0000 ^ (i * 32'h0011_0203);
      end
      gp_mem[3] = 32'hDEAD_BEEF;
      fp_mem[2] = 32'h3F80_0000;

      #2;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_wr_en", {gp_wr_en, fp_wr_en}, 0);
      chk("rst_rd_en", {gp_rd_en, fp_rd_en}, 0);
      chk("rst_stall", pipe_stall, 0);
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);

      run_xfer(1'b1, 5'd3,  5'd7,  0,  0);   // basic mtc1
      run_xfer(1'b0, 5'd2,  5'd9,  0,  0);   // basic mfc1
      run_xfer(1'b0, 5'd4,  5'd0,  0,  99);  // mfc1 to GP $0, conflict ignored
      run_xfer(1'b1, 5'd8,  5'd0,  0,  0);   // mtc1 writes FP $0
      run_xfer(1'b1, 5'd5,  5'd12, 2,  0);   // two-cycle yield
      run_xfer(1'b1, 5'd6,  5'd13, 99, 0);   // starvation -> stall
      run_xfer(1'b1, 5'd10, 5'd14, 0,  99);  // other-file conflict: no delay
      run_xfer(1'b0, 5'd11, 5'd15, 99, 0);   // other-file conflict: no delay
      run_xfer(1'b0, 5'd12, 5'd16, 0,  MW);  // exactly MAX_WAIT yields, no stall
      run_xfer(1'b0, 5'd13, 5'd17, 0,  99);  // mfc1 starvation

      // Reset mid-WRITE aborts without write or done.
      req_valid = 1'b1; req_is_mtc1 = 1'b1; req_src = 5'd5; req_dst = 5'd6;
      pipe_fp_wr_req = 1'b1;
      @(posedge clk); #1; req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("pre_rst_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_req_ready", req_ready, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_wr_en", {gp_wr_en, fp_wr_en}, 0);
      chk("mid_rst_stall", pipe_stall, 0);
      @(posedge clk); #1; rst = 1'b0;
      wr_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (fp_wr_en || gp_wr_en || done) wr_cnt++;
      end
      chk("post_rst_no_write", wr_cnt, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_req_ready", req_ready, 1);
      pipe_fp_wr_req = 1'b0;

      run_xfer(1'b0, 5'd2, 5'd21, 0, 1);   // recovers after reset

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
